// File: rtl/fp_share_pkg.sv
// Shared types and constants for the float32 multiplier arbiter.
package fp_share_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_UNIT_RST = 3'd1,
        S_SEND_A   = 3'd2,
        S_SEND_B   = 3'd3,
        S_WAIT_Z   = 3'd4,
        S_RETURN   = 3'd5
    } state_t;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO = 32'h4000_0000;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side and multiplier-side handshake bundle of the shared multiplier arbiter.
interface fp_mul_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
);
    logic [N-1:0]   req_stb;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   res_z;
    logic [N-1:0]   res_stb;
    logic [N-1:0]   res_ack;
    logic [W-1:0]   unit_a;
    logic [W-1:0]   unit_b;
    logic           unit_a_stb;
    logic           unit_b_stb;
    logic           unit_a_ack;
    logic           unit_b_ack;
    logic [W-1:0]   unit_z;
    logic           unit_z_stb;
    logic           unit_z_ack;
    logic           unit_rst;
    logic           busy;

    // Arbiter side
    modport master (
        input  req_stb, req_a, req_b, res_ack,
        input  unit_a_ack, unit_b_ack, unit_z, unit_z_stb,
        output req_ack, res_z, res_stb,
        output unit_a, unit_b, unit_a_stb, unit_b_stb, unit_z_ack, unit_rst, busy
    );

    // Requesters plus multiplier side
    modport slave (
        output req_stb, req_a, req_b, res_ack,
        output unit_a_ack, unit_b_ack, unit_z, unit_z_stb,
        input  req_ack, res_z, res_stb,
        input  unit_a, unit_b, unit_a_stb, unit_b_stb, unit_z_ack, unit_rst, busy
    );
endinterface

// File: rtl/fp_mul_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_c,
    output logic          any_req_c
);

    int            sum;
    logic [PW-1:0] idx;

    // Scan highest offset first so the closest request to ptr wins.
    always_comb begin
        grant_c   = '0;
        any_req_c = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= int'(N)) begin
                sum = sum - int'(N);
            end
            idx = PW'(sum);
            if (req[idx]) begin
                grant_c   = idx;
                any_req_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one float32 multiplier among N requesters with round-robin grants
// and stb/ack handshakes on both sides.
module fp_mul_arbiter
    import fp_share_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             rst,
    fp_mul_arbiter_if.master bus
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] pick;
    logic          any_req;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    logic [N-1:0]  req_ack_q;
    logic [N-1:0]  res_stb_q;
    logic [W-1:0]  res_z_q;
    logic [W-1:0]  unit_a_q;
    logic [W-1:0]  unit_b_q;
    logic          a_stb_q;
    logic          b_stb_q;
    logic          z_ack_q;
    logic          unit_rst_q;
    logic          busy_q;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req       (bus.req_stb),
        .ptr       (ptr),
        .grant_c   (pick),
        .any_req_c (any_req)
    );

    // Operand slice of the candidate requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pick == PW'(i)) begin
                sel_a = bus.req_a[i*W +: W];
                sel_b = bus.req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            gnt        <= '0;
            req_ack_q  <= '0;
            res_stb_q  <= '0;
            res_z_q    <= '0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            a_stb_q    <= 1'b0;
            b_stb_q    <= 1'b0;
            z_ack_q    <= 1'b0;
            unit_rst_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt       <= pick;
                        unit_a_q  <= sel_a;
                        unit_b_q  <= sel_b;
                        req_ack_q <= N'(1) << pick;
                        busy_q    <= 1'b1;
                        state     <= S_UNIT_RST;
                    end
                end
                S_UNIT_RST: begin
                    unit_rst_q <= 1'b0;
                    req_ack_q  <= '0;
                    a_stb_q    <= 1'b1;
                    state      <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (a_stb_q && bus.unit_a_ack) begin
                        a_stb_q <= 1'b0;
                        b_stb_q <= 1'b1;
                        state   <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (b_stb_q && bus.unit_b_ack) begin
                        b_stb_q <= 1'b0;
                        state   <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    if (bus.unit_z_stb) begin
                        res_z_q   <= bus.unit_z;
                        z_ack_q   <= 1'b1;
                        res_stb_q <= N'(1) << gnt;
                        state     <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    z_ack_q <= 1'b0;
                    // Only the granted requester's ack completes the operation.
                    if (bus.res_ack[gnt]) begin
                        res_stb_q  <= '0;
                        ptr        <= (gnt == PW'(N - 1)) ? '0 : gnt + PW'(1);
                        busy_q     <= 1'b0;
                        unit_rst_q <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.res_stb    = res_stb_q;
    assign bus.res_z      = res_z_q;
    assign bus.unit_a     = unit_a_q;
    assign bus.unit_b     = unit_b_q;
    assign bus.unit_a_stb = a_stb_q;
    assign bus.unit_b_stb = b_stb_q;
    assign bus.unit_z_ack = z_ack_q;
    assign bus.unit_rst   = unit_rst_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a table-driven float32 multiplier stand-in.
module tb_fp_mul_arbiter;
    import fp_share_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;
    localparam logic [31:0] FP_1P5   = 32'h3FC0_0000;
    localparam logic [31:0] FP_THREE = 32'h4040_0000;
    localparam logic [31:0] FP_FOUR  = 32'h4080_0000;
    localparam logic [31:0] FP_SIX   = 32'h40C0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        z_en;
    logic [31:0] ma;
    logic [31:0] mb;
    int          total = 0;
    int          bad   = 0;

    fp_mul_arbiter_if #(.N(N), .W(W)) bus ();

    fp_mul_arbiter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Hand-computed products for the operand pairs used below.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            {FP_ONE,   FP_TWO}: return FP_TWO;
            {FP_1P5,   FP_TWO}: return FP_THREE;
            {FP_TWO,   FP_TWO}: return FP_FOUR;
            {FP_THREE, FP_TWO}: return FP_SIX;
            default:            return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.unit_a_stb && bus.unit_a_ack) ma <= bus.unit_a;
        if (bus.unit_b_stb && bus.unit_b_ack) mb <= bus.unit_b;
    end

    assign bus.unit_z     = fmul_ref(ma, mb);
    assign bus.unit_z_stb = z_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic wait_ack(input string tag, input int idx, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = |bus.req_ack;
        end
        check({tag, "_req_ack"}, 32'(bus.req_ack), 32'(1) << idx);
        if (drop) bus.req_stb[idx] = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int idx, input logic [31:0] z);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = |bus.res_stb;
        end
        check({tag, "_res_stb"}, 32'(bus.res_stb), 32'(1) << idx);
        check({tag, "_res_z"}, bus.res_z, z);
        check({tag, "_z_ack"}, 32'(bus.unit_z_ack), 32'd1);
    endtask

    task automatic finish_res(input string tag, input int idx);
        bus.res_ack = 4'(1) << idx;
        @(negedge clk);
        bus.res_ack = '0;
        check({tag, "_done_stb"}, 32'(bus.res_stb), 32'd0);
        check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_urst"}, 32'(bus.unit_rst), 32'd1);
    endtask

    task automatic serve(input string tag, input int idx, input logic [31:0] z, input bit drop);
        wait_ack(tag, idx, drop);
        wait_res(tag, idx, z);
        finish_res(tag, idx);
    endtask

    initial begin
        rst            = 1'b1;
        z_en           = 1'b1;
        bus.req_stb    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.res_ack    = '0;
        bus.unit_a_ack = 1'b1;
        bus.unit_b_ack = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_urst", 32'(bus.unit_rst), 32'd1);
        check("rst_req_ack", 32'(bus.req_ack), 32'd0);
        check("rst_res_stb", 32'(bus.res_stb), 32'd0);
        check("rst_res_z", bus.res_z, 32'd0);
        check("rst_unit_a", bus.unit_a, 32'd0);
        check("rst_unit_b", bus.unit_b, 32'd0);
        check("rst_a_stb", 32'(bus.unit_a_stb), 32'd0);
        check("rst_z_ack", 32'(bus.unit_z_ack), 32'd0);
        rst = 1'b0;

        // Single request from requester 0: 1.0 * 2.0
        set_req(0, FP_ONE, FP_TWO);
        bus.req_stb = 4'b0001;
        wait_ack("t1", 0, 1'b1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_urst_hi", 32'(bus.unit_rst), 32'd1);
        check("t1_a_stb_lo", 32'(bus.unit_a_stb), 32'd0);
        check("t1_unit_a", bus.unit_a, FP_ONE);
        check("t1_unit_b", bus.unit_b, FP_TWO);
        @(negedge clk);
        check("t1_ack_pulse", 32'(bus.req_ack), 32'd0);
        check("t1_urst_lo", 32'(bus.unit_rst), 32'd0);
        check("t1_a_stb_hi", 32'(bus.unit_a_stb), 32'd1);
        check("t1_b_stb_lo", 32'(bus.unit_b_stb), 32'd0);
        wait_res("t1", 0, FP_TWO);
        @(negedge clk);
        check("t1_z_ack_once", 32'(bus.unit_z_ack), 32'd0);
        check("t1_res_hold", 32'(bus.res_stb), 32'd1);
        finish_res("t1", 0);

        // All four requesting continuously after reset: grants 0,1,2,3,0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, FP_1P5, FP_TWO);
        bus.req_stb = 4'b1111;
        for (int k = 0; k < 5; k++) serve("t2", k % 4, FP_THREE, 1'b0);
        bus.req_stb = '0;

        // Move ptr to 2, then requesters 1 and 3 pending: 3 first
        set_req(1, FP_THREE, FP_TWO);
        bus.req_stb = 4'b0010;
        serve("t3a", 1, FP_SIX, 1'b1);
        set_req(3, FP_TWO, FP_TWO);
        bus.req_stb = 4'b1010;
        serve("t3b", 3, FP_FOUR, 1'b1);
        serve("t3c", 1, FP_SIX, 1'b1);

        // Delayed operand handshakes on requester 2
        bus.unit_a_ack = 1'b0;
        bus.unit_b_ack = 1'b0;
        set_req(2, FP_ONE, FP_TWO);
        bus.req_stb = 4'b0100;
        wait_ack("t4", 2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_a_wait_a", 32'(bus.unit_a_stb), 32'd1);
            check("t4_a_wait_b", 32'(bus.unit_b_stb), 32'd0);
        end
        bus.unit_a_ack = 1'b1;
        @(negedge clk);
        bus.unit_a_ack = 1'b0;
        check("t4_a_done_a", 32'(bus.unit_a_stb), 32'd0);
        check("t4_a_done_b", 32'(bus.unit_b_stb), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_b_wait", 32'(bus.unit_b_stb), 32'd1);
            check("t4_b_wait_z", 32'(bus.unit_z_ack), 32'd0);
        end
        bus.unit_b_ack = 1'b1;
        @(negedge clk);
        bus.unit_a_ack = 1'b1;
        check("t4_b_done", 32'(bus.unit_b_stb), 32'd0);
        check("t4_no_res_yet", 32'(bus.res_stb), 32'd0);
        wait_res("t4", 2, FP_TWO);

        // Held result; other res_ack bits and a new request must not interfere
        set_req(0, FP_TWO, FP_TWO);
        bus.req_stb = 4'b0001;
        bus.res_ack = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_hold_stb", 32'(bus.res_stb), 32'b0100);
            check("t5_hold_z", bus.res_z, FP_TWO);
            check("t5_no_grant", 32'(bus.req_ack), 32'd0);
            check("t5_z_ack_lo", 32'(bus.unit_z_ack), 32'd0);
        end
        finish_res("t5", 2);
        serve("t5b", 0, FP_FOUR, 1'b1);

        // Reset while waiting for the product; ptr (now 1) must return to 0
        z_en = 1'b0;
        set_req(2, FP_ONE, FP_TWO);
        bus.req_stb = 4'b0100;
        wait_ack("t6", 2, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_wz_busy", 32'(bus.busy), 32'd1);
        check("t6_wz_urst", 32'(bus.unit_rst), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_stb", 32'(bus.res_stb), 32'd0);
        check("t6_rst_urst", 32'(bus.unit_rst), 32'd1);
        z_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, FP_1P5, FP_TWO);
        set_req(2, FP_TWO, FP_TWO);
        bus.req_stb = 4'b0101;
        serve("t6a", 0, FP_THREE, 1'b1);
        serve("t6b", 2, FP_FOUR, 1'b1);

        // Reset while a result is presented
        set_req(1, FP_THREE, FP_TWO);
        bus.req_stb = 4'b0010;
        wait_ack("t7", 1, 1'b1);
        wait_res("t7", 1, FP_SIX);
        rst = 1'b1;
        #1;
        check("t7_rst_stb", 32'(bus.res_stb), 32'd0);
        check("t7_rst_z_ack", 32'(bus.unit_z_ack), 32'd0);
        check("t7_rst_res_z", bus.res_z, 32'd0);
        check("t7_rst_urst", 32'(bus.unit_rst), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
